// File: rtl/sa_sched_pkg.sv
// Shared types and descriptor layout for the systolic-array job scheduler.
package sa_sched_pkg;

    localparam int unsigned LEN_W = 16;

    // Descriptor bases are packed a, b, c from bit 0 upward, then stream_len, then flush_len.
    localparam int unsigned A_IDX = 0;
    localparam int unsigned B_IDX = 1;
    localparam int unsigned C_IDX = 2;

    typedef enum logic [1:0] {
        ST_OK      = 2'd0,
        ST_TIMEOUT = 2'd1,
        ST_ERR_LEN = 2'd2
    } status_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_CPL
    } state_e;

    function automatic int unsigned desc_w(input int unsigned aw);
        return 3 * aw + 2 * LEN_W;
    endfunction

    function automatic int unsigned base_lsb(input int unsigned aw, input int unsigned idx);
        return idx * aw;
    endfunction

    function automatic int unsigned slen_lsb(input int unsigned aw);
        return 3 * aw;
    endfunction

    function automatic int unsigned flen_lsb(input int unsigned aw);
        return 3 * aw + LEN_W;
    endfunction

endpackage

// File: rtl/sa_rr_pick.sv
// Combinational rotate-priority picker: first asserted request at or above
// i_ptr wins, otherwise the first one below it.
module sa_rr_pick #(
    parameter int unsigned N  = 2,
    parameter int unsigned PW = 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [PW-1:0] i_ptr,
    output logic [N-1:0]  o_grant,
    output logic [PW-1:0] o_idx,
    output logic          o_any
);

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        for (int unsigned j = 0; j < N; j++) begin
            if (!o_any && i_req[j] && (j >= 32'(i_ptr))) begin
                o_any      = 1'b1;
                o_grant[j] = 1'b1;
                o_idx      = PW'(j);
            end
        end
        for (int unsigned j = 0; j < N; j++) begin
            if (!o_any && i_req[j] && (j < 32'(i_ptr))) begin
                o_any      = 1'b1;
                o_grant[j] = 1'b1;
                o_idx      = PW'(j);
            end
        end
    end

endmodule

// File: rtl/sa_job_scheduler.sv
// Arbitrates job descriptors from NUM_REQ requesters onto one systolic matmul
// engine, supervises each job with a timeout and returns a completion status.
module sa_job_scheduler
    import sa_sched_pkg::*;
#(
    parameter int unsigned NUM_REQ         = 2,
    parameter int unsigned BRAM_ADDR_WIDTH = 11,
    parameter int unsigned TIMEOUT_CYCLES  = 4096,
    localparam int unsigned AW     = BRAM_ADDR_WIDTH,
    localparam int unsigned DESC_W = desc_w(BRAM_ADDR_WIDTH),
    localparam int unsigned OW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*DESC_W-1:0] req_desc,
    output logic [NUM_REQ-1:0]        cpl_valid,
    input  logic [NUM_REQ-1:0]        cpl_ready,
    output logic [1:0]                cpl_status,
    output logic                      eng_start,
    output logic [AW-1:0]             eng_a_base,
    output logic [AW-1:0]             eng_b_base,
    output logic [AW-1:0]             eng_c_base,
    output logic [15:0]               eng_stream_len,
    output logic [15:0]               eng_flush_len,
    input  logic                      eng_done,
    output logic                      eng_abort,
    output logic                      busy,
    output logic [OW-1:0]             owner,
    output logic                      stray_done
);

    localparam int unsigned TW     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);
    localparam int unsigned A_LSB  = base_lsb(AW, A_IDX);
    localparam int unsigned B_LSB  = base_lsb(AW, B_IDX);
    localparam int unsigned C_LSB  = base_lsb(AW, C_IDX);
    localparam int unsigned S_LSB  = slen_lsb(AW);
    localparam int unsigned F_LSB  = flen_lsb(AW);

    state_e             r_state;
    state_e             w_next;
    logic [OW-1:0]      r_ptr;
    logic [OW-1:0]      r_owner;
    logic [TW-1:0]      r_timer;
    status_e            r_status;
    logic [AW-1:0]      r_a;
    logic [AW-1:0]      r_b;
    logic [AW-1:0]      r_c;
    logic [15:0]        r_slen;
    logic [15:0]        r_flen;
    logic               r_stray;

    logic [NUM_REQ-1:0] w_grant;
    logic [OW-1:0]      w_win;
    logic               w_any;
    logic [DESC_W-1:0]  w_desc;
    logic [NUM_REQ-1:0] w_owner_oh;
    logic               w_hs_req;
    logic               w_hs_cpl;
    logic               w_expire;
    logic               w_len_zero;

    sa_rr_pick #(
        .N  (NUM_REQ),
        .PW (OW)
    ) u_pick (
        .i_req   (req_valid),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_win),
        .o_any   (w_any)
    );

    always_comb begin
        w_desc     = '0;
        w_owner_oh = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (w_win == OW'(i)) begin
                w_desc = req_desc[i*DESC_W +: DESC_W];
            end
            w_owner_oh[i] = (r_owner == OW'(i));
        end
    end

    assign w_len_zero = (w_desc[S_LSB +: 16] == 16'd0);
    assign w_hs_req   = (r_state == S_IDLE) && w_any && !rst;
    assign w_hs_cpl   = (r_state == S_CPL) && ((cpl_ready & w_owner_oh) != '0);
    // A done arriving on the expiry cycle wins, so expiry is qualified by !eng_done.
    assign w_expire   = (r_state == S_WAIT) && (r_timer == TMAX) && !eng_done && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        req_ready = '0;
        cpl_valid = '0;
        eng_start = 1'b0;
        eng_abort = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_hs_req) begin
                    req_ready = w_grant;
                    w_next    = w_len_zero ? S_CPL : S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                eng_start = !rst;
                w_next    = S_WAIT;
            end
            S_WAIT: begin
                eng_abort = w_expire;
                if (eng_done || w_expire) begin
                    w_next = S_CPL;
                end
            end
            S_CPL: begin
                cpl_valid = w_owner_oh;
                if (w_hs_cpl) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr    <= '0;
            r_owner  <= '0;
            r_timer  <= '0;
            r_status <= ST_OK;
            r_a      <= '0;
            r_b      <= '0;
            r_c      <= '0;
            r_slen   <= '0;
            r_flen   <= '0;
            r_stray  <= 1'b0;
        end else begin
            if (eng_done && (r_state != S_WAIT)) begin
                r_stray <= 1'b1;
            end
            if (w_hs_req) begin
                r_owner  <= w_win;
                r_a      <= w_desc[A_LSB +: AW];
                r_b      <= w_desc[B_LSB +: AW];
                r_c      <= w_desc[C_LSB +: AW];
                r_slen   <= w_desc[S_LSB +: 16];
                r_flen   <= w_desc[F_LSB +: 16];
                r_status <= w_len_zero ? ST_ERR_LEN : ST_OK;
            end
            if (r_state == S_LAUNCH) begin
                r_timer <= '0;
            end else if ((r_state == S_WAIT) && (r_timer != '1)) begin
                r_timer <= r_timer + 1'b1;
            end
            if (r_state == S_WAIT) begin
                if (eng_done) begin
                    r_status <= ST_OK;
                end else if (w_expire) begin
                    r_status <= ST_TIMEOUT;
                end
            end
            if (w_hs_cpl) begin
                r_ptr <= (r_owner == OW'(NUM_REQ - 1)) ? '0 : r_owner + 1'b1;
            end
        end
    end

    assign cpl_status     = r_status;
    assign eng_a_base     = r_a;
    assign eng_b_base     = r_b;
    assign eng_c_base     = r_c;
    assign eng_stream_len = r_slen;
    assign eng_flush_len  = r_flen;
    assign busy           = (r_state != S_IDLE);
    assign owner          = r_owner;
    assign stray_done     = r_stray;

endmodule

// File: tb/tb_sa_job_scheduler.sv
// Directed bench: one scheduler with the default timeout and one with a
// 16-cycle timeout, sharing clock, reset, descriptors and cpl_ready.
module tb_sa_job_scheduler;

    localparam int unsigned AW = 11;
    localparam int unsigned DW = 3 * AW + 32;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [2*DW-1:0] desc = '0;
    logic [1:0]      cpl_ready = '0;

    logic [1:0]  m_valid = '0, m_ready, m_cplv, m_status;
    logic        m_start, m_done = 1'b0, m_abort, m_busy, m_stray;
    logic [0:0]  m_owner;
    logic [AW-1:0] m_a, m_b, m_c;
    logic [15:0] m_slen, m_flen;

    logic [1:0]  t_valid = '0, t_ready, t_cplv, t_status;
    logic        t_start, t_done = 1'b0, t_abort, t_busy, t_stray;
    logic [0:0]  t_owner;
    logic [AW-1:0] t_a, t_b, t_c;
    logic [15:0] t_slen, t_flen;

    int n_vec = 0;
    int n_err = 0;
    int n_start_m = 0, n_abort_m = 0, n_start_t = 0, n_abort_t = 0;

    always #5 clk = ~clk;

    sa_job_scheduler #(
        .NUM_REQ         (2),
        .BRAM_ADDR_WIDTH (AW)
    ) u_main (
        .clk (clk), .rst (rst),
        .req_valid (m_valid), .req_ready (m_ready), .req_desc (desc),
        .cpl_valid (m_cplv), .cpl_ready (cpl_ready), .cpl_status (m_status),
        .eng_start (m_start), .eng_a_base (m_a), .eng_b_base (m_b), .eng_c_base (m_c),
        .eng_stream_len (m_slen), .eng_flush_len (m_flen),
        .eng_done (m_done), .eng_abort (m_abort),
        .busy (m_busy), .owner (m_owner), .stray_done (m_stray)
    );

    sa_job_scheduler #(
        .NUM_REQ         (2),
        .BRAM_ADDR_WIDTH (AW),
        .TIMEOUT_CYCLES  (16)
    ) u_to (
        .clk (clk), .rst (rst),
        .req_valid (t_valid), .req_ready (t_ready), .req_desc (desc),
        .cpl_valid (t_cplv), .cpl_ready (cpl_ready), .cpl_status (t_status),
        .eng_start (t_start), .eng_a_base (t_a), .eng_b_base (t_b), .eng_c_base (t_c),
        .eng_stream_len (t_slen), .eng_flush_len (t_flen),
        .eng_done (t_done), .eng_abort (t_abort),
        .busy (t_busy), .owner (t_owner), .stray_done (t_stray)
    );

    always @(negedge clk) begin
        if (m_start) n_start_m++;
        if (m_abort) n_abort_m++;
        if (t_start) n_start_t++;
        if (t_abort) n_abort_t++;
    end

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] mkdesc(input logic [AW-1:0] a, input logic [AW-1:0] b,
                                             input logic [AW-1:0] c, input logic [15:0] s,
                                             input logic [15:0] f);
        return {f, s, c, b, a};
    endfunction

    logic [1:0] grants [6];
    int ng;
    int found;
    logic prev_start;

    initial begin
        // Reset state
        repeat (3) tick;
        rst = 1'b0;
        #1;
        check_vec("rst_busy", m_busy, 0);
        check_vec("rst_cplv", m_cplv, 0);
        check_vec("rst_ready", m_ready, 0);
        check_vec("rst_start", m_start, 0);
        check_vec("rst_abort", m_abort, 0);
        check_vec("rst_owner", m_owner, 0);
        check_vec("rst_stray", m_stray, 0);
        check_vec("rst_status", m_status, 0);
        check_vec("rst_slen", m_slen, 0);
        check_vec("rst_t_busy", t_busy, 0);

        // Single job on the default-timeout instance, done 20 cycles after start
        desc[0 +: DW] = mkdesc(11'd0, 11'd0, 11'd0, 16'd8, 16'd8);
        m_valid = 2'b01;
        #1;
        check_vec("sj_ready", m_ready, 2'b01);
        check_vec("sj_start_pre", m_start, 0);
        tick;
        m_valid = 2'b00;
        #1;
        check_vec("sj_start", m_start, 1);
        check_vec("sj_slen", m_slen, 8);
        check_vec("sj_flen", m_flen, 8);
        check_vec("sj_ready_off", m_ready, 0);
        repeat (20) tick;
        m_done = 1'b1;
        #1;
        check_vec("sj_cplv_wait", m_cplv, 0);
        tick;
        m_done = 1'b0;
        cpl_ready = 2'b10;
        #1;
        check_vec("sj_cplv", m_cplv, 2'b01);
        check_vec("sj_status", m_status, 0);
        check_vec("sj_owner", m_owner, 0);
        tick;
        #1;
        check_vec("sj_cplv_hold", m_cplv, 2'b01);
        cpl_ready = 2'b01;
        tick;
        cpl_ready = 2'b00;
        #1;
        check_vec("sj_idle", m_busy, 0);
        check_vec("sj_nstart", n_start_m, 1);

        // Timeout with no done on the 16-cycle instance
        desc[0 +: DW] = mkdesc(11'h010, 11'h020, 11'h030, 16'd8, 16'd8);
        t_valid = 2'b01;
        #1;
        check_vec("to_ready", t_ready, 2'b01);
        tick;
        t_valid = 2'b00;
        #1;
        check_vec("to_start", t_start, 1);
        found = 0;
        for (int k = 1; k <= 40 && found == 0; k++) begin
            tick;
            #1;
            if (t_abort) found = k;
        end
        check_vec("to_abort_lat", found, 16);
        check_vec("to_cplv_pre", t_cplv, 0);
        tick;
        #1;
        check_vec("to_cplv", t_cplv, 2'b01);
        check_vec("to_status", t_status, 1);
        check_vec("to_abort_cnt", n_abort_t, 1);
        cpl_ready = 2'b01;
        tick;
        cpl_ready = 2'b00;
        #1;
        check_vec("to_idle", t_busy, 0);

        // Done on the expiry cycle: done wins, latched config held through CPL
        desc[0 +: DW] = mkdesc(11'h123, 11'h2A5, 11'h7FF, 16'h1234, 16'hBEEF);
        t_valid = 2'b01;
        tick;
        t_valid = 2'b00;
        #1;
        check_vec("co_start", t_start, 1);
        check_vec("co_a", t_a, 11'h123);
        check_vec("co_b", t_b, 11'h2A5);
        check_vec("co_c", t_c, 11'h7FF);
        check_vec("co_slen", t_slen, 16'h1234);
        check_vec("co_flen", t_flen, 16'hBEEF);
        repeat (16) tick;
        t_done = 1'b1;
        #1;
        check_vec("co_abort", t_abort, 0);
        tick;
        t_done = 1'b0;
        #1;
        check_vec("co_cplv", t_cplv, 2'b01);
        check_vec("co_status", t_status, 0);
        check_vec("co_abort_cnt", n_abort_t, 1);
        check_vec("co_a_hold", t_a, 11'h123);
        check_vec("co_flen_hold", t_flen, 16'hBEEF);
        cpl_ready = 2'b01;
        tick;
        cpl_ready = 2'b00;

        // Zero stream length from requester 1: straight to completion
        desc[DW +: DW] = mkdesc(11'd1, 11'd2, 11'd3, 16'd0, 16'd5);
        t_valid = 2'b10;
        #1;
        check_vec("el_ready", t_ready, 2'b10);
        tick;
        t_valid = 2'b00;
        #1;
        check_vec("el_start", t_start, 0);
        check_vec("el_cplv", t_cplv, 2'b10);
        check_vec("el_status", t_status, 2);
        check_vec("el_owner", t_owner, 1);
        check_vec("el_nstart", n_start_t, 2);
        cpl_ready = 2'b10;
        tick;
        cpl_ready = 2'b00;
        #1;
        check_vec("el_idle", t_busy, 0);

        // Done while idle is flagged and otherwise ignored
        check_vec("sd_pre", t_stray, 0);
        t_done = 1'b1;
        tick;
        t_done = 1'b0;
        #1;
        check_vec("sd_stray", t_stray, 1);
        check_vec("sd_busy", t_busy, 0);
        check_vec("sd_cplv", t_cplv, 0);

        // Reset on the would-be expiry cycle: no abort, everything cleared
        desc[0 +: DW] = mkdesc(11'h055, 11'h066, 11'h077, 16'd8, 16'd8);
        t_valid = 2'b01;
        tick;
        t_valid = 2'b00;
        repeat (16) tick;
        rst = 1'b1;
        #1;
        check_vec("rw_abort_gated", t_abort, 0);
        tick;
        rst = 1'b0;
        #1;
        check_vec("rw_busy", t_busy, 0);
        check_vec("rw_abort", t_abort, 0);
        check_vec("rw_cplv", t_cplv, 0);
        check_vec("rw_owner", t_owner, 0);
        check_vec("rw_status", t_status, 0);
        check_vec("rw_a", t_a, 0);
        check_vec("rw_stray", t_stray, 0);
        check_vec("rw_abort_cnt", n_abort_t, 1);

        // Contention on the main instance after reset: grants must alternate from 0
        m_valid = 2'b11;
        cpl_ready = 2'b11;
        ng = 0;
        prev_start = 1'b0;
        for (int cyc = 0; cyc < 200; cyc++) begin
            if (ng == 6) m_valid = 2'b00;
            m_done = prev_start;
            #1;
            prev_start = m_start;
            if (m_ready != 2'b00 && ng < 6) begin
                grants[ng] = m_ready;
                ng++;
            end else if (ng == 6 && !m_busy) begin
                break;
            end
            tick;
        end
        m_valid = 2'b00;
        m_done = 1'b0;
        cpl_ready = 2'b00;
        check_vec("ct_count", ng, 6);
        for (int i = 0; i < 6; i++) begin
            check_vec($sformatf("ct_grant%0d", i), (i < ng) ? 32'(grants[i]) : 32'd0,
                      (i % 2 == 0) ? 32'd1 : 32'd2);
        end
        check_vec("ct_idle", m_busy, 0);
        check_vec("m_abort_cnt", n_abort_m, 0);
        check_vec("m_stray", m_stray, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sa_job_scheduler.md
SA_JOB_SCHEDULER -- requirements
Module: sa_job_scheduler

Interface
REQ-001 SHALL have parameter NUM_REQ, default 2, number of requesters sharing one 4x4 systolic matmul engine.
REQ-002 SHALL have parameter BRAM_ADDR_WIDTH (AW), default 11, word-address width of the engine's A/B/C buffers.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 4096, maximum cycles from engine start to engine done.
REQ-004 SHALL use one clock; reset is synchronous and active-high: clk input 1, rising-edge clock; rst input 1, synchronous active-high reset.
REQ-005 SHALL have req_valid input NUM_REQ, one job request per requester.
REQ-006 SHALL have req_ready output NUM_REQ, descriptor accepted from requester i.
REQ-007 SHALL have req_desc input NUM_REQ*DESC_W, per requester {flush_len[15:0], stream_len[15:0], c_base[AW-1:0], b_base[AW-1:0], a_base[AW-1:0]}, slot i at [i*DESC_W +: DESC_W], DESC_W=3*AW+32.
REQ-008 SHALL have cpl_valid output NUM_REQ, completion pending for requester i.
REQ-009 SHALL have cpl_ready input NUM_REQ, completion consumed by requester i.
REQ-010 SHALL have cpl_status output 2, 0=OK, 1=TIMEOUT, 2=ERR_LEN.
REQ-011 SHALL have eng_start output 1, one-cycle start pulse to the engine.
REQ-012 SHALL have eng_a_base, eng_b_base and eng_c_base outputs AW each, plus eng_stream_len and eng_flush_len outputs 16 each: the latched job configuration.
REQ-013 SHALL have eng_done input 1, engine completion pulse.
REQ-014 SHALL have eng_abort output 1, one-cycle abort pulse to the engine.
REQ-015 SHALL have busy output 1, high when state is not IDLE.
REQ-016 SHALL have owner output $clog2(NUM_REQ), index of the current job's requester.
REQ-017 SHALL have stray_done output 1, sticky flag set by eng_done outside WAIT.

Function
REQ-018 SHALL implement FSM IDLE -> LAUNCH -> WAIT -> CPL -> IDLE, with a direct IDLE -> CPL path for ERR_LEN.
REQ-019 In IDLE, SHALL pick winner = first i with req_valid[i], searching from rr_ptr upward modulo NUM_REQ; req_ready[winner] SHALL be asserted combinationally in that cycle only, one-hot, and never outside IDLE.
REQ-020 On handshake, SHALL latch the descriptor and owner; if stream_len==0, go to CPL with ERR_LEN and no eng_start; otherwise go to LAUNCH.
REQ-021 LAUNCH SHALL assert eng_start for exactly one cycle (one cycle after handshake), clear the timer and go to WAIT.
REQ-022 eng_* config outputs SHALL hold the latched values stable from LAUNCH through CPL.
REQ-023 WAIT: on eng_done, status=OK -> CPL; if the timer reaches TIMEOUT_CYCLES-1 without done, pulse eng_abort one cycle, status=TIMEOUT -> CPL.
REQ-024 If eng_done and timer expiry coincide, done SHALL win: status OK, no eng_abort.
REQ-025 CPL SHALL hold cpl_valid[owner] and cpl_status until cpl_ready[owner]; cpl_ready on other indices SHALL be ignored.
REQ-026 On the CPL handshake, SHALL set rr_ptr = (owner+1) mod NUM_REQ and return to IDLE; a new grant SHALL occur no earlier than the next cycle.
REQ-027 Timer SHALL be $clog2(TIMEOUT_CYCLES) bits, saturating, counting only in WAIT.
REQ-028 eng_done in IDLE/LAUNCH/CPL SHALL be ignored for control and SHALL set stray_done.
REQ-029 Deassertion of req_valid before grant SHALL drop that request with no side effects.

Reset
REQ-030 rst SHALL force IDLE, rr_ptr=0, owner=0, timer=0, stray_done=0, and all req_ready/cpl_valid/eng_start/eng_abort/busy/cpl_status/eng_* outputs to 0.
REQ-031 Reset mid-WAIT SHALL NOT emit eng_abort; the engine is reset by the same rst.

Structure
REQ-032 Package sa_sched_pkg SHALL hold DESC field offsets/widths, status codes and the state enum.
REQ-033 Sub-module sa_rr_pick (combinational rotate-priority picker, NUM_REQ-wide) SHALL be used for winner selection.

Verification
REQ-034 Single job: req0 with a_base=0, b_base=0, c_base=0, stream_len=8, flush_len=8; done 20 cycles after start -> eng_start 1 cycle after ready, cpl_valid[0], status 0.
REQ-035 Contention: req0 and req1 both held valid for 3 jobs each -> grant order 0,1,0,1,0,1.
REQ-036 Timeout: TIMEOUT_CYCLES=16, no done -> eng_abort 16 cycles after eng_start (timer 0..15), status 1.
REQ-037 stream_len=0 -> no eng_start, cpl_valid next cycle, status 2.
REQ-038 Done coinciding with timeout expiry -> status 0, no abort; eng_done while IDLE -> stray_done=1, state unchanged.
REQ-039 rst asserted in WAIT -> next cycle all outputs 0, no eng_abort, rr_ptr=0.
